// File: rtl/aes_inv_round_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : aes_inv_round_ctrl                                              |
// | Purpose  : Sequencing controller for an AES-128 decryption datapath.       |
// |            Accepts a ciphertext block, applies the initial AddRoundKey     |
// |            with the last round key, then steps an external combinational   |
// |            inverse-round unit once per clock while walking the round-key   |
// |            index down to zero, and presents the plaintext on an output     |
// |            valid/ready handshake.                                          |
// | Ports    : clk, rst         - clock, synchronous active-high reset         |
// |            key_ready        - key store holds a valid expanded key         |
// |            in_valid/in_ready/in_data    - ciphertext input handshake       |
// |            rk_idx/rk_data   - round-key index out, round key back          |
// |            dp_state/dp_last/dp_result   - inverse-round unit interface     |
// |            out_valid/out_ready/out_data - plaintext output handshake       |
// |            busy             - block in flight (ROUND or DONE)              |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module aes_inv_round_ctrl #(
  parameter int NR = 10,
  parameter int DW = 128
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          key_ready,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  output logic [3:0]    rk_idx,
  input  logic [DW-1:0] rk_data,
  output logic [DW-1:0] dp_state,
  output logic          dp_last,
  input  logic [DW-1:0] dp_result,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic          busy
);

  localparam logic [3:0] RK_LAST   = 4'(NR);
  localparam logic [3:0] RND_FIRST = 4'(NR - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUND = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t        fsm;
  logic [3:0]    rnd;
  logic [DW-1:0] st;

  // Acceptance follows key_ready combinationally so a block can be taken in
  // the same cycle the key store becomes valid; forced low while in reset.
  assign in_ready = (fsm == IDLE) && key_ready && !rst;

  // The state register feeds both the datapath and the output port; since st
  // only changes in IDLE (on accept) and ROUND, out_data is stable in DONE.
  assign dp_state = st;
  assign out_data = st;
  assign dp_last  = (fsm == ROUND) && (rnd == 4'd0);

  // In IDLE the key store is pointed at the last round key so the initial
  // AddRoundKey can be folded into the accept cycle.
  always_comb begin
    rk_idx = 4'd0;
    case (fsm)
      IDLE:    rk_idx = RK_LAST;
      ROUND:   rk_idx = rnd;
      default: rk_idx = 4'd0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fsm       <= IDLE;
      rnd       <= 4'd0;
      st        <= '0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (fsm)
        IDLE: begin
          if (in_valid && in_ready) begin
            st   <= in_data ^ rk_data;
            rnd  <= RND_FIRST;
            fsm  <= ROUND;
            busy <= 1'b1;
          end
        end
        ROUND: begin
          st <= dp_result;
          if (rnd == 4'd0) begin
            fsm       <= DONE;
            out_valid <= 1'b1;
          end else begin
            rnd <= rnd - 4'd1;
          end
        end
        DONE: begin
          if (out_ready) begin
            fsm       <= IDLE;
            out_valid <= 1'b0;
            busy      <= 1'b0;
          end
        end
        default: begin
          fsm       <= IDLE;
          out_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_aes_inv_round_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_aes_inv_round_ctrl                                           |
// | Purpose  : Testbench for aes_inv_round_ctrl. Models the key store and the  |
// |            combinational inverse-round unit, and predicts plaintext with a |
// |            full AES-128 inverse cipher held in a scoreboard queue.         |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_aes_inv_round_ctrl;

  localparam int NR = 10;
  localparam int DW = 128;
  localparam logic [127:0] FIPS_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] FIPS_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] FIPS_PT  = 128'h00112233445566778899aabbccddeeff;

  logic          clk = 1'b0;
  logic          rst;
  logic          key_ready;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic [3:0]    rk_idx;
  logic [DW-1:0] rk_data;
  logic [DW-1:0] dp_state;
  logic          dp_last;
  logic [DW-1:0] dp_result;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic          busy;

  int checks = 0;
  int errors = 0;

  logic [127:0]      exp_q[$];
  logic [127:0]      cur_key;
  logic [11*128-1:0] ks;

  aes_inv_round_ctrl #(.NR(NR), .DW(DW)) dut (
    .clk(clk), .rst(rst), .key_ready(key_ready),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .rk_idx(rk_idx), .rk_data(rk_data),
    .dp_state(dp_state), .dp_last(dp_last), .dp_result(dp_result),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .busy(busy)
  );

  always #5 clk = ~clk;

  // ---------------- GF(2^8) / AES helpers ----------------
  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
    logic [7:0] a, b, p;
    a = a_in; b = b_in; p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = xt(a);
      b = b >> 1;
    end
    return p;
  endfunction

  // x^254 is the multiplicative inverse (and maps 0 to 0).
  function automatic logic [7:0] ginv(input logic [7:0] x);
    logic [7:0] r, b;
    logic [7:0] e;
    r = 8'h01; b = x; e = 8'd254;
    for (int i = 0; i < 8; i++) begin
      if (e[i]) r = gmul(r, b);
      b = gmul(b, b);
    end
    return r;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    return (b << n) | (b >> (8 - n));
  endfunction

  function automatic logic [7:0] sb(input logic [7:0] x);
    logic [7:0] b;
    b = ginv(x);
    return b ^ rotl8(b, 1) ^ rotl8(b, 2) ^ rotl8(b, 3) ^ rotl8(b, 4) ^ 8'h63;
  endfunction

  function automatic logic [7:0] isb(input logic [7:0] y);
    return ginv(rotl8(y, 1) ^ rotl8(y, 3) ^ rotl8(y, 6) ^ 8'h05);
  endfunction

  // Byte i of a block sits at bits [127-8i -: 8]; state[r][c] = byte r+4c.
  function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        o[127-8*(r+4*((c+r)%4)) -: 8] = s[127-8*(r+4*c) -: 8];
    return o;
  endfunction

  function automatic logic [127:0] inv_sub(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int i = 0; i < 16; i++) o[127-8*i -: 8] = isb(s[127-8*i -: 8]);
    return o;
  endfunction

  function automatic logic [127:0] inv_mix(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0] a0, a1, a2, a3;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-8*(4*c)   -: 8];
      a1 = s[127-8*(4*c+1) -: 8];
      a2 = s[127-8*(4*c+2) -: 8];
      a3 = s[127-8*(4*c+3) -: 8];
      o[127-8*(4*c)   -: 8] = gmul(a0,8'h0e)^gmul(a1,8'h0b)^gmul(a2,8'h0d)^gmul(a3,8'h09);
      o[127-8*(4*c+1) -: 8] = gmul(a0,8'h09)^gmul(a1,8'h0e)^gmul(a2,8'h0b)^gmul(a3,8'h0d);
      o[127-8*(4*c+2) -: 8] = gmul(a0,8'h0d)^gmul(a1,8'h09)^gmul(a2,8'h0e)^gmul(a3,8'h0b);
      o[127-8*(4*c+3) -: 8] = gmul(a0,8'h0b)^gmul(a1,8'h0d)^gmul(a2,8'h09)^gmul(a3,8'h0e);
    end
    return o;
  endfunction

  // Round key r lives at ks[r*128 +: 128].
  function automatic logic [11*128-1:0] expand_key(input logic [127:0] key);
    logic [31:0] w [0:43];
    logic [31:0] t;
    logic [7:0]  rcon;
    logic [11*128-1:0] o;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    rcon = 8'h01;
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sb(t[31:24]), sb(t[23:16]), sb(t[15:8]), sb(t[7:0])} ^ {rcon, 24'h0};
        rcon = xt(rcon);
      end
      w[i] = w[i-4] ^ t;
    end
    o = '0;
    for (int r = 0; r <= 10; r++) o[r*128 +: 128] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    return o;
  endfunction

  // Reference: complete AES-128 inverse cipher from ciphertext and cipher key.
  function automatic logic [127:0] aes_decrypt(input logic [127:0] ct, input logic [127:0] key);
    logic [11*128-1:0] k;
    logic [127:0] s;
    k = expand_key(key);
    s = ct ^ k[10*128 +: 128];
    for (int r = 9; r >= 0; r--) begin
      s = inv_sub(inv_shift_rows(s)) ^ k[r*128 +: 128];
      if (r != 0) s = inv_mix(s);
    end
    return s;
  endfunction

  // ---------------- environment: key store + inverse-round unit ----------------
  always_comb begin
    rk_data = '0;
    if (rk_idx <= 4'd10) rk_data = ks[int'(rk_idx)*128 +: 128];
  end

  always_comb begin
    logic [127:0] t;
    t = inv_sub(inv_shift_rows(dp_state)) ^ rk_data;
    dp_result = dp_last ? t : inv_mix(t);
  end

  // ---------------- checking ----------------
  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s: got timeout expected event", name);
  endtask

  // Scoreboard: push predicted plaintext on accept, pop and compare on output.
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
    end else begin
      if (in_valid && in_ready) exp_q.push_back(aes_decrypt(in_data, cur_key));
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL scoreboard_unexpected: got %h expected no output", out_data);
        end else begin
          check("scoreboard_out_data", out_data, exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [127:0] blk);
    bit done;
    done = 0;
    in_valid = 1'b1;
    in_data  = blk;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      if (in_ready) done = 1;
      tick();
    end
    in_valid = 1'b0;
    if (!done) fail_now("send_accept");
  endtask

  task automatic wait_out();
    bit seen;
    seen = 0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      if (out_valid) seen = 1;
    end
    if (!seen) fail_now("wait_out_valid");
  endtask

  initial begin
    logic [127:0] blk;
    int n_acc, n_out, n;
    int t_out [0:2];
    bit fire, hit;

    rst = 1'b1; key_ready = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
    cur_key = FIPS_KEY;
    ks = expand_key(FIPS_KEY);

    // Reset state
    tick();
    @(negedge clk);
    check("reset_in_ready", in_ready, 0);
    check("reset_out_valid", out_valid, 0);
    check("reset_busy", busy, 0);
    check("reset_dp_state", dp_state, 0);
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("idle_in_ready", in_ready, 1);
    check("idle_rk_idx", rk_idx, NR);
    check("idle_dp_last", dp_last, 0);

    // FIPS-197 C.1 with latency and round-key index sequence
    tick();
    out_ready = 1'b1;
    send(FIPS_CT);
    for (int k = 1; k <= NR + 1; k++) begin
      @(negedge clk);
      if (k <= NR) begin
        check("round_rk_idx", rk_idx, NR - k);
        check("round_dp_last", dp_last, (k == NR) ? 1 : 0);
        check("round_out_valid", out_valid, 0);
        check("round_busy", busy, 1);
      end else begin
        check("latency_out_valid", out_valid, 1);
        check("fips_out_data", out_data, FIPS_PT);
        check("done_rk_idx", rk_idx, 0);
      end
    end
    tick();
    @(negedge clk);
    check("after_done_busy", busy, 0);
    check("after_done_rk_idx", rk_idx, NR);

    // Backpressure: hold output for 5 cycles
    tick();
    out_ready = 1'b0;
    send(FIPS_CT);
    wait_out();
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge clk);
      check("bp_out_valid", out_valid, 1);
      check("bp_out_data", out_data, FIPS_PT);
      check("bp_in_ready", in_ready, 0);
      check("bp_busy", busy, 1);
    end
    tick();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    @(negedge clk);
    check("bp_release_busy", busy, 0);
    check("bp_release_out_valid", out_valid, 0);
    check("bp_release_in_ready", in_ready, 1);

    // key_ready gating
    tick();
    key_ready = 1'b0;
    in_valid = 1'b1;
    in_data = FIPS_CT;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("kr_in_ready", in_ready, 0);
      check("kr_busy", busy, 0);
      tick();
    end
    key_ready = 1'b1;
    @(negedge clk);
    check("kr_in_ready_rise", in_ready, 1);
    tick();
    in_valid = 1'b0;
    @(negedge clk);
    check("kr_accepted_busy", busy, 1);
    out_ready = 1'b1;
    wait_out();
    tick();

    // in_valid held during ROUND with a different block
    blk = {$urandom, $urandom, $urandom, $urandom};
    send(FIPS_CT);
    in_valid = 1'b1;
    in_data = blk;
    hit = 0;
    for (int i = 0; i < 30 && !hit; i++) begin
      @(negedge clk);
      if (out_valid) hit = 1;
      else check("hold_in_ready_busy", in_ready, 0);
    end
    if (!hit) fail_now("hold_first_out");
    check("hold_first_result", out_data, FIPS_PT);
    tick();
    @(negedge clk);
    check("hold_gap_in_ready", in_ready, 1);
    check("hold_gap_busy", busy, 0);
    tick();
    in_valid = 1'b0;
    @(negedge clk);
    check("hold_second_busy", busy, 1);
    wait_out();
    check("hold_second_result", out_data, aes_decrypt(blk, FIPS_KEY));
    tick();

    // Reset in the middle of a block (rnd = 5)
    send(FIPS_CT);
    hit = 0;
    for (int i = 0; i < 20 && !hit; i++) begin
      @(negedge clk);
      if (rk_idx == 4'd6) hit = 1;
    end
    if (!hit) fail_now("rst_find_round");
    tick();
    rst = 1'b1;
    @(negedge clk);
    check("rst_at_rnd5", rk_idx, 5);
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("rst_dp_state", dp_state, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_rk_idx", rk_idx, NR);
    tick();
    blk = {$urandom, $urandom, $urandom, $urandom};
    send(blk);
    wait_out();
    check("rst_new_block", out_data, aes_decrypt(blk, FIPS_KEY));
    tick();

    // Back-to-back: 3 blocks, outputs spaced NR+2 cycles
    out_ready = 1'b1;
    in_valid = 1'b1;
    in_data = FIPS_CT;
    n_acc = 0;
    n_out = 0;
    for (int i = 0; i < 100 && n_out < 3; i++) begin
      @(negedge clk);
      if (out_valid) begin
        t_out[n_out] = i;
        n_out++;
      end
      if (in_valid && in_ready) n_acc++;
      tick();
      if (n_acc == 3) in_valid = 1'b0;
    end
    in_valid = 1'b0;
    check("b2b_count", n_out, 3);
    if (n_out == 3) begin
      check("b2b_spacing_01", t_out[1] - t_out[0], NR + 2);
      check("b2b_spacing_12", t_out[2] - t_out[1], NR + 2);
    end

    // Randomized traffic with a random key
    cur_key = {$urandom, $urandom, $urandom, $urandom};
    ks = expand_key(cur_key);
    n = 0;
    for (int i = 0; i < 3000 && n < 40; i++) begin
      @(negedge clk);
      fire = in_valid && in_ready;
      tick();
      if (fire) begin
        n++;
        in_valid = 1'b0;
      end
      if (!in_valid && n < 40 && ($urandom % 3 == 0)) begin
        in_valid = 1'b1;
        in_data = {$urandom, $urandom, $urandom, $urandom};
      end
      out_ready = ($urandom % 4) != 0;
      key_ready = ($urandom % 5) != 0;
    end
    in_valid = 1'b0;
    key_ready = 1'b1;
    out_ready = 1'b1;
    check("random_accepts", n, 40);
    for (int i = 0; i < 100 && (exp_q.size() != 0 || busy); i++) @(negedge clk);
    check("drain_queue_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/aes_inv_round_ctrl.md
Name: aes_inv_round_ctrl

Overview:
Sequencing controller for the AES-128 decryption datapath. It accepts a ciphertext block over a valid/ready handshake and applies the initial AddRoundKey itself. It then iterates the external combinational inverse-round unit (InvShiftRows, InvSubBytes, AddRoundKey, InvMixColumns) once per clock. It selects the round-key index for the key store and presents the plaintext on an output handshake. It sits between the block input interface and the inverse-round/key-schedule datapath.

Parameters:
NR, 10, number of AES rounds; round-key indices run NR..0
DW, 128, block width in bits

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  synchronous active-high reset
key_ready  input  1  expanded round keys valid in key store
in_valid  input  1  ciphertext block valid
in_ready  output  1  controller can accept a block
in_data  input  DW  ciphertext block
rk_idx  output  4  round-key index driven to key store
rk_data  input  DW  round key for rk_idx, combinational same cycle
dp_state  output  DW  current state to inverse-round unit
dp_last  output  1  high on the final round (skip InvMixColumns)
dp_result  input  DW  inverse-round unit result, combinational same cycle
out_valid  output  1  plaintext valid
out_ready  input  1  downstream accepts plaintext
out_data  output  DW  plaintext block
busy  output  1  high in ROUND or DONE

Behaviour:
- Clock is clk; reset is rst, synchronous, active-high; the single clock domain is fixed.
- States: IDLE, ROUND, DONE. Round counter rnd is 4 bits. State register st is DW bits.
- Reset values: FSM=IDLE, rnd=0, st=0, out_valid=0, busy=0, in_ready=0 in the reset cycle.
- After reset, in_ready=key_ready while in IDLE. in_ready is 0 in ROUND and DONE.
- IDLE:
  - rk_idx=NR.
  - On in_valid && in_ready: st <= in_data ^ rk_data, rnd <= NR-1, go to ROUND.
- ROUND:
  - rk_idx=rnd, dp_state=st, dp_last=(rnd==0).
  - Each cycle: st <= dp_result.
  - If rnd==0, go to DONE; else rnd <= rnd-1.
- DONE:
  - out_valid=1, out_data=st.
  - On out_ready: go to IDLE.
  - out_data is held stable while out_valid && !out_ready.
- dp_state=st in all states. dp_last=0 outside ROUND.
- Latency:
  - Accept at edge T.
  - NR round edges T+1..T+NR.
  - out_valid is high from the cycle following edge T+NR, i.e. NR+1 cycles after acceptance.
- Throughput: one block per NR+2 cycles minimum. IDLE is always visited for at least one cycle between blocks, so no back-to-back accept in DONE.
- key_ready:
  - Sampled only for acceptance in IDLE.
  - Deasserting it mid-operation does not abort the block (key store is required to hold keys until busy=0).
- in_valid while busy: ignored, no state change; the upstream holds the block until in_ready.
- rst asserted in any state: next cycle is IDLE with all reset values. Any in-flight block is discarded and out_valid drops.
- out_ready without out_valid: no effect.
- rk_idx in DONE = 0 (don't-care for the key store, driven deterministically).

Test Plan:
- FIPS-197 C.1: key 000102030405060708090a0b0c0d0e0f expanded, key_ready=1, in_data=69c4e0d86a7b0430d8cdb78070b4c55a -> out_data=00112233445566778899aabbccddeeff. out_valid rises exactly 11 cycles after the accept edge. rk_idx sequence: 10, 9, ..., 0.
- Backpressure: same vector with out_ready=0 for 5 cycles -> out_valid and out_data stable for all 5 cycles, in_ready=0, busy=1. Single out_ready pulse -> IDLE next cycle.
- key_ready=0 with in_valid=1 for 4 cycles -> in_ready=0, no accept, busy=0. key_ready=1 -> accept on that cycle.
- in_valid held high during ROUND with a different block -> ignored. First result still 00112233445566778899aabbccddeeff. Second block accepted only after DONE handshake plus one IDLE cycle.
- rst asserted at round rnd=5 -> next cycle FSM=IDLE, out_valid=0, st=0. A new block is then decrypted correctly with no residue.
- Back-to-back: 3 FIPS blocks with out_ready=1 constant -> 3 correct outputs spaced 12 cycles apart.
